snax_tcdm_responder: RTL and testbench

Single-port TCDM responder: the memory-side end of the TCDM request/response interface that SNAX streamer and accelerator wrappers drive as initiators. It accepts one request per cycle, performs byte-strobed writes into a local word array, and returns read data a fixed `ReadLatency` cycles later. It is the standalone TCDM target for accelerator-wrapper benches and small integrations that do not need the full interconnect.

---
 rtl/snax_tcdm_responder_pkg.sv | 21 ++
 rtl/snax_tcdm_rsp_delay.sv | 42 ++++
 rtl/snax_tcdm_responder.sv | 128 ++++++++++++
 tb/tb_snax_tcdm_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snax_tcdm_responder_pkg.sv
// Shared constants and types for the single-port TCDM responder.
// Optional stall feature is selected with SNAX_TCDM_RESPONDER_STALL_EN.
package snax_tcdm_responder_pkg;

  localparam logic [3:0] AmoNone = 4'h0;

  localparam int unsigned MinReadLatency = 1;
  localparam int unsigned MaxReadLatency = 4;

  // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1, taps expressed as bit mask.
  localparam int unsigned             LfsrWidth = 16;
  localparam logic [LfsrWidth-1:0]    LfsrTaps  = 16'hB400;

  localparam int unsigned RspDataWidth = 64;

  typedef struct packed {
    logic                    valid;
    logic [RspDataWidth-1:0] data;
  } rsp_stage_t;

endpackage

// File: rtl/snax_tcdm_rsp_delay.sv
// Fixed-depth response delay line; each stage carries a valid flag and data.
// Flushed synchronously on reset so in-flight responses are never emitted.
module snax_tcdm_rsp_delay
  import snax_tcdm_responder_pkg::*;
#(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Depth     = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  input  logic [DataWidth-1:0] in_data_i,
  output logic                 out_valid_o,
  output logic [DataWidth-1:0] out_data_o
);

  // Same shape as rsp_stage_t, widened to the instance data width.
  typedef struct packed {
    logic                 valid;
    logic [DataWidth-1:0] data;
  } stage_t;

  stage_t stage_q [Depth];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0].valid <= in_valid_i;
      stage_q[0].data  <= in_valid_i ? in_data_i : '0;
      for (int unsigned i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign out_valid_o = stage_q[Depth-1].valid;
  assign out_data_o  = stage_q[Depth-1].valid ? stage_q[Depth-1].data : '0;

endmodule

// File: rtl/snax_tcdm_responder.sv
// TCDM target: byte-strobed word array, fixed-latency read responses, sticky error.
// Define SNAX_TCDM_RESPONDER_STALL_EN to add LFSR-driven request backpressure.
module snax_tcdm_responder
  import snax_tcdm_responder_pkg::*;
#(
  parameter int unsigned     DataWidth   = 64,
  parameter int unsigned     AddrWidth   = 32,
  parameter int unsigned     NumWords    = 1024,
  parameter int unsigned     ReadLatency = 1,
  parameter logic [15:0]     LfsrSeed    = 16'hACE1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   tcdm_req_write_i,
  input  logic [AddrWidth-1:0]   tcdm_req_addr_i,
  input  logic [3:0]             tcdm_req_amo_i,
  input  logic [DataWidth-1:0]   tcdm_req_data_i,
  input  logic [DataWidth/8-1:0] tcdm_req_strb_i,
  input  logic [4:0]             tcdm_req_user_core_id_i,
  input  logic                   tcdm_req_user_is_core_i,
  input  logic                   tcdm_req_q_valid_i,
  output logic                   tcdm_rsp_q_ready_o,
  output logic                   tcdm_rsp_p_valid_o,
  output logic [DataWidth-1:0]   tcdm_rsp_data_o,
  output logic                   err_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned OffWidth  = $clog2(StrbWidth);
  localparam int unsigned IdxWidth  = $clog2(NumWords);
  localparam int unsigned HiLsb     = OffWidth + IdxWidth;

  logic                 rst_q;
  logic                 err_q;
  logic                 q_ready;
  logic                 req_accept;
  logic                 out_of_range;
  logic                 req_bad;
  logic                 wr_en;
  logic                 rd_accept;
  logic [IdxWidth-1:0]  word_idx;
  logic [DataWidth-1:0] rd_data;
  logic [DataWidth-1:0] mem_q [NumWords];
  logic [5:0]           dbg_user_q;
  logic                 unused_dbg;

  // Ready is derived from a registered reset so the cycle after a reset edge shows 0.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rst_q <= 1'b0;
    end else begin
      rst_q <= 1'b1;
    end
  end

`ifdef SNAX_TCDM_RESPONDER_STALL_EN
  logic [LfsrWidth-1:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= {lfsr_q[LfsrWidth-2:0], ^(lfsr_q & LfsrTaps)};
    end
  end

  assign q_ready = rst_q & (lfsr_q[1:0] != 2'b00);
`else
  localparam logic [15:0] UnusedLfsrSeed = LfsrSeed;

  assign q_ready = rst_q;
`endif

  assign tcdm_rsp_q_ready_o = q_ready;

  // Address decode: byte offset ignored, any bit above the index field is out of range.
  assign word_idx     = tcdm_req_addr_i[OffWidth +: IdxWidth];
  assign out_of_range = |(tcdm_req_addr_i >> HiLsb);
  assign req_bad      = out_of_range | (tcdm_req_amo_i != AmoNone);
  assign req_accept   = tcdm_req_q_valid_i & q_ready;
  assign wr_en        = rst_ni & req_accept & tcdm_req_write_i & ~req_bad;
  assign rd_accept    = req_accept & ~tcdm_req_write_i;
  assign rd_data      = req_bad ? '0 : mem_q[word_idx];

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < StrbWidth; b++) begin
        if (tcdm_req_strb_i[b]) begin
          mem_q[word_idx][b*8 +: 8] <= tcdm_req_data_i[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (req_accept && req_bad) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  // Initiator identity of the last accepted request, kept for waveform debug.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      dbg_user_q <= '0;
    end else if (req_accept) begin
      dbg_user_q <= {tcdm_req_user_is_core_i, tcdm_req_user_core_id_i};
    end
  end

  assign unused_dbg = ^dbg_user_q;

  snax_tcdm_rsp_delay #(
    .DataWidth (DataWidth),
    .Depth     (ReadLatency)
  ) i_rsp_delay (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (rd_accept),
    .in_data_i   (rd_data),
    .out_valid_o (tcdm_rsp_p_valid_o),
    .out_data_o  (tcdm_rsp_data_o)
  );

endmodule

// File: tb/tb_snax_tcdm_responder.sv
// Scoreboard bench for snax_tcdm_responder (ReadLatency = 3) with a byte-merge memory model.
module tb_snax_tcdm_responder;

  localparam int unsigned RL = 3;
  localparam int unsigned NW = 1024;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_amo;
  logic [63:0] req_data;
  logic [7:0]  req_strb;
  logic [4:0]  req_core_id;
  logic        req_is_core;
  logic        req_valid;
  logic        ready;
  logic        p_valid;
  logic [63:0] rsp_data;
  logic        err;

  always #5 clk = ~clk;

  snax_tcdm_responder #(
    .DataWidth   (64),
    .AddrWidth   (32),
    .NumWords    (NW),
    .ReadLatency (RL),
    .LfsrSeed    (16'hACE1)
  ) dut (
    .clk_i                   (clk),
    .rst_ni                  (rst_ni),
    .tcdm_req_write_i        (req_write),
    .tcdm_req_addr_i         (req_addr),
    .tcdm_req_amo_i          (req_amo),
    .tcdm_req_data_i         (req_data),
    .tcdm_req_strb_i         (req_strb),
    .tcdm_req_user_core_id_i (req_core_id),
    .tcdm_req_user_is_core_i (req_is_core),
    .tcdm_req_q_valid_i      (req_valid),
    .tcdm_rsp_q_ready_o      (ready),
    .tcdm_rsp_p_valid_o      (p_valid),
    .tcdm_rsp_data_o         (rsp_data),
    .err_o                   (err)
  );

  typedef struct {
    logic [63:0] data;
    int unsigned due;
  } exp_t;

  exp_t        exp_q [$];
  logic [63:0] ref_mem [NW];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned live_cycles  = 0;
  int unsigned stall_cycles = 0;
  bit          live      = 1'b0;
  bit          err_model = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard on every p_valid and checks data, timing, err, ready.
  always @(negedge clk) begin
    if (live) begin
      live_cycles++;
      if (!ready) stall_cycles++;
      if (p_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_pvalid", 64'(p_valid), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("rsp_data", rsp_data, e.data);
          check_eq("rsp_cycle", 64'(cyc), 64'(e.due));
        end
      end else begin
        check_eq("idle_data", rsp_data, 64'd0);
        if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
          check_eq("missing_pvalid", 64'(p_valid), 64'd1);
          void'(exp_q.pop_front());
        end
      end
      check_eq("err", 64'(err), 64'(err_model));
`ifndef SNAX_TCDM_RESPONDER_STALL_EN
      check_eq("ready_high", 64'(ready), 64'd1);
`endif
    end
  end

  task automatic do_reset(input int unsigned n);
    live      = 1'b0;
    rst_ni    = 1'b0;
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    exp_q.delete();
    err_model = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", 64'(ready), 64'd0);
    check_eq("rst_pvalid", 64'(p_valid), 64'd0);
    check_eq("rst_data", rsp_data, 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    live = 1'b1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one request until accepted, then applies it to the model and scoreboard.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [63:0] data,
                       input logic [7:0] strb, input logic [3:0] amo);
    bit          acc = 1'b0;
    int unsigned waited = 0;
    int unsigned cs = 0;
    bit          bad;
    logic [9:0]  idx;
    req_write   = wr;
    req_addr    = addr;
    req_data    = data;
    req_strb    = strb;
    req_amo     = amo;
    req_core_id = 5'($urandom_range(0, 31));
    req_is_core = 1'($urandom_range(0, 1));
    req_valid   = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = ready;
      cs  = cyc;
      @(posedge clk);
      if (!acc) begin
        waited++;
        if (waited > 64) break;
      end
    end
    #1;
    req_valid = 1'b0;
    if (!acc) begin
      check_eq("accept_timeout", 64'(acc), 64'd1);
      return;
    end
    bad = (addr[31:13] != 19'd0) || (amo != 4'h0);
    idx = addr[12:3];
    if (bad) err_model = 1'b1;
    if (wr && !bad) begin
      for (int b = 0; b < 8; b++) begin
        if (strb[b]) ref_mem[idx][b*8 +: 8] = data[b*8 +: 8];
      end
    end
    if (!wr) exp_q.push_back('{data: (bad ? 64'd0 : ref_mem[idx]), due: cs + RL});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    req_write = 1'b0; req_addr = '0; req_amo = '0; req_data = '0;
    req_strb = '0; req_core_id = '0; req_is_core = 1'b0; req_valid = 1'b0;
    do_reset(3);

    // Full write then read; the write itself must not produce p_valid.
    issue(1'b1, 32'h40, 64'hDEADBEEF_CAFEF00D, 8'hFF, 4'h0);
    idle(RL + 1);
    issue(1'b0, 32'h40, '0, '0, 4'h0);
    idle(RL + 1);

    // Partial strobe on low half -> DEADBEEF_55667788.
    issue(1'b1, 32'h40, 64'h11223344_55667788, 8'h0F, 4'h0);
    issue(1'b0, 32'h40, '0, '0, 4'h0);
    idle(RL + 1);

    // Strobe 0 leaves the word unchanged; byte offset bits are ignored.
    issue(1'b1, 32'h45, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 4'h0);
    issue(1'b0, 32'h47, '0, '0, 4'h0);
    idle(RL + 1);

    // Eight preloaded words read back to back.
    for (int i = 0; i < 8; i++)
      issue(1'b1, 32'h100 + 32'(i * 8), {32'hA5A50000 + 32'(i), 32'h0F0F0000 + 32'(i * 3)}, 8'hFF, 4'h0);
    for (int i = 0; i < 8; i++)
      issue(1'b0, 32'h100 + 32'(i * 8), '0, '0, 4'h0);
    idle(RL + 2);

    // Write then read of the same word in consecutive cycles.
    issue(1'b1, 32'h48, 64'h0123_4567_89AB_CDEF, 8'hFF, 4'h0);
    issue(1'b0, 32'h48, '0, '0, 4'h0);
    idle(RL + 1);

    // Out-of-range read returns 0 and sets err; AMO write is dropped.
    issue(1'b0, 32'(NW * 8), '0, '0, 4'h0);
    idle(RL + 1);
    issue(1'b1, 32'h40, 64'h0, 8'hFF, 4'h2);
    issue(1'b0, 32'h40, '0, '0, 4'h0);
    issue(1'b1, 32'(NW * 8) + 32'h40, 64'h0, 8'hFF, 4'h0);
    issue(1'b0, 32'h40, '0, '0, 4'h0);
    idle(RL + 1);

    // Reset with two reads in flight: neither may be emitted.
    issue(1'b0, 32'h100, '0, '0, 4'h0);
    issue(1'b0, 32'h108, '0, '0, 4'h0);
    do_reset(1);
    idle(RL + 4);

    // Random traffic over a preloaded window with occasional bad requests.
    for (int i = 0; i < 16; i++)
      issue(1'b1, 32'h800 + 32'(i * 8), {$urandom, $urandom}, 8'hFF, 4'h0);
    for (int n = 0; n < 1000; n++) begin
      logic [31:0] a;
      logic [3:0]  amo;
      int unsigned kind;
      a    = 32'h800 + 32'($urandom_range(0, 15) * 8) + 32'($urandom_range(0, 7));
      amo  = 4'h0;
      kind = $urandom_range(0, 19);
      if (kind == 0) a = a | 32'h0000_2000 << $urandom_range(0, 18);
      else if (kind == 1) amo = 4'($urandom_range(1, 15));
      issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom), amo);
    end
    idle(RL + 3);

    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
`ifdef SNAX_TCDM_RESPONDER_STALL_EN
    check_eq("stall_pct_20_30",
             64'((100 * stall_cycles >= 20 * live_cycles) && (100 * stall_cycles <= 30 * live_cycles)),
             64'd1);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
